// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM states, MMIO window base and register offsets.
package data_mem_resp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmemState_t;

    localparam logic [15:0] MMIO_HI = 16'hFFFF;
    localparam logic [15:0] OFF_OUT = 16'h0000;
    localparam logic [15:0] OFF_CYC = 16'h0004;
    localparam logic [15:0] OFF_STC = 16'h0008;

    function automatic logic isAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_resp_mmio.sv
// Memory-mapped I/O block for data_mem_resp: OUT register, RUN-cycle counter, RAM-store counter.
// Only compiled when DMEM_MMIO_EN is defined.
`ifdef DMEM_MMIO_EN
module data_mem_resp_mmio
    import data_mem_resp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              running,
    input  logic              mmioStore,
    input  logic              ramStore,
    input  logic [15:0]       offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] outReg
);

    logic [13:0]       regSel;
    logic [DATA_W-1:0] cycCnt;
    logic [DATA_W-1:0] stcCnt;
    logic              unusedLowBits;

    // Registers are selected by word offset; byte lane bits never matter here.
    assign regSel        = offset[15:2];
    assign unusedLowBits = ^offset[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outReg <= '0;
            cycCnt <= '0;
            stcCnt <= '0;
        end else begin
            if (mmioStore && regSel == OFF_OUT[15:2]) begin
                outReg <= wdata;
            end
            if (running) begin
                cycCnt <= cycCnt + DATA_W'(1);
            end
            if (ramStore) begin
                stcCnt <= stcCnt + DATA_W'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (regSel == OFF_OUT[15:2]) begin
            rdata = outReg;
        end else if (regSel == OFF_CYC[15:2]) begin
            rdata = cycCnt;
        end else if (regSel == OFF_STC[15:2]) begin
            rdata = stcCnt;
        end
    end

endmodule
`endif

// File: rtl/data_mem_resp.sv
// MEM-stage data-memory responder: word RAM with combinational read, synchronous write and a
// post-reset zero sweep. Define DMEM_MMIO_EN to add the MMIO window at 0xFFFF_xxxx.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_wd,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ready,
    output logic              mem_err,
    output logic [DATA_W-1:0] mmio_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    dmemState_t        state, nextState;
    logic [ADDR_W-1:0] clrPtr;
    logic [ADDR_W-1:0] wordIdx;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] mmioRdata;
    logic              running;
    logic              aligned;
    logic              inWindow;
    logic              ramStore;
    logic              unusedAddrBits;

    assign wordIdx        = mem_addr[ADDR_W+1:2];
    assign aligned        = isAligned(mem_addr[1:0]);
    assign unusedAddrBits = ^mem_addr[31:ADDR_W+2];

`ifdef DMEM_MMIO_EN
    assign inWindow = (mem_addr[31:16] == MMIO_HI);

    data_mem_resp_mmio #(
        .DATA_W(DATA_W)
    ) mmio (
        .clk      (clk),
        .rst_n    (rst_n),
        .running  (running),
        .mmioStore(running && mem_we && aligned && inWindow),
        .ramStore (ramStore),
        .offset   (mem_addr[15:0]),
        .wdata    (mem_wd),
        .rdata    (mmioRdata),
        .outReg   (mmio_out)
    );
`else
    assign inWindow  = 1'b0;
    assign mmioRdata = '0;
    assign mmio_out  = '0;
`endif

    assign ramStore  = running && mem_we && aligned && !inWindow;
    assign mem_ready = running;

    // The sweep finishes on the edge that clears the last word.
    always_comb begin
        nextState = state;
        running   = 1'b0;
        case (state)
            ST_INIT: begin
                if (&clrPtr) begin
                    nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                running = 1'b1;
            end
            default: begin
                nextState = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clrPtr  <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= nextState;
            if (state == ST_INIT) begin
                clrPtr <= clrPtr + ADDR_W'(1);
            end
            if (running && mem_we && !aligned) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Array has no reset; the sweep is what guarantees zeroed contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                ram[clrPtr] <= '0;
            end else if (ramStore) begin
                ram[wordIdx] <= mem_wd;
            end
        end
    end

    always_comb begin
        mem_data_o = '0;
        if (running) begin
            mem_data_o = inWindow ? mmioRdata : ram[wordIdx];
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (ADDR_W=4): directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural memory model.
module tb_data_mem_resp;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef DMEM_MMIO_EN
    localparam bit MmioOn = 1'b1;
`else
    localparam bit MmioOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_data_o;
    logic        mem_ready;
    logic        mem_err;
    logic [31:0] mmio_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_resp #(
        .ADDR_W(AW),
        .DATA_W(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_data_o(mem_data_o),
        .mem_ready (mem_ready),
        .mem_err   (mem_err),
        .mmio_out  (mmio_out)
    );

    // Behavioural model: the array is simply zero after any reset, and stays invisible for DEPTH cycles.
    bit          modelValid = 1'b0;
    int          initLeft;
    logic [31:0] mRam [DEPTH];
    bit          mErr;
    logic [31:0] mOut;
    logic [31:0] mCyc;
    logic [31:0] mStc;

    function automatic bit inWindow(input logic [31:0] a);
        return MmioOn && (a >> 16) == 32'hFFFF;
    endfunction

    function automatic logic [31:0] expData(input logic [31:0] a);
        if (initLeft != 0) return 32'h0;
        if (inWindow(a)) begin
            case ((a & 32'hFFFF) / 4)
                0:       return mOut;
                1:       return mCyc;
                2:       return mStc;
                default: return 32'h0;
            endcase
        end
        return mRam[(a / 4) % DEPTH];
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            modelValid = 1'b1;
            initLeft   = DEPTH;
            for (int i = 0; i < DEPTH; i++) mRam[i] = 32'h0;
            mErr = 1'b0;
            mOut = 32'h0;
            mCyc = 32'h0;
            mStc = 32'h0;
        end else if (modelValid) begin
            if (initLeft > 0) begin
                initLeft--;
            end else begin
                mCyc++;
                if (mem_we) begin
                    if (mem_addr % 4 != 0) begin
                        mErr = 1'b1;
                    end else if (inWindow(mem_addr)) begin
                        if ((mem_addr & 32'hFFFF) == 0) mOut = mem_wd;
                    end else begin
                        mRam[(mem_addr / 4) % DEPTH] = mem_wd;
                        mStc++;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("modelData", mem_data_o, expData(mem_addr));
            checkOutput("modelReady", {31'h0, mem_ready}, {31'h0, initLeft == 0});
            checkOutput("modelErr", {31'h0, mem_err}, {31'h0, mErr});
            checkOutput("modelMmioOut", mmio_out, mOut);
        end
    end

    task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd);
        @(posedge clk);
        #2;
        rst_n    = rst;
        mem_we   = we;
        mem_addr = addr;
        mem_wd   = wd;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 32'h0;
        mem_wd   = 32'h0;

        // Reset, then a full 16-cycle sweep before the port comes alive.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'h0);
            checkOutput("initReady", {31'h0, mem_ready}, 32'h0);
            checkOutput("initData", mem_data_o, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i * 12), 32'h0);
            checkOutput("readyAfterSweep", {31'h0, mem_ready}, 32'h1);
            checkOutput("clearedData", mem_data_o, 32'h0);
        end

        // Read-during-write returns old data.
        applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        checkOutput("sameCycleOld", mem_data_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("storedWord", mem_data_o, 32'hDEADBEEF);

        // Misaligned store is dropped and latches the error.
        applyStimulus(1'b1, 1'b1, 32'h42, 32'h12345678);
        checkOutput("errBeforeEdge", {31'h0, mem_err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("misalignedDropped", mem_data_o, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h8, 32'h0);
            checkOutput("errSticky", {31'h0, mem_err}, 32'h1);
        end

        // Aliasing: word 1 also answers at 0x44.
        applyStimulus(1'b1, 1'b1, 32'h4, 32'h11);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
        checkOutput("aliasRead", mem_data_o, 32'h11);

`ifdef DMEM_MMIO_EN
        applyStimulus(1'b1, 1'b1, 32'hFFFF0000, 32'hA5);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("mmioOut", mmio_out, 32'hA5);
        checkOutput("ramUntouched", mem_data_o, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'(8 + i * 4), 32'(i));
        applyStimulus(1'b1, 1'b0, 32'hFFFF0008, 32'h0);
        checkOutput("storeCount", mem_data_o, 32'h5);
`endif

        // Reset from RUN, then again mid-sweep: each restarts a full sweep.
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
            checkOutput("runResetReady", {31'h0, mem_ready}, 32'h0);
            checkOutput("runResetErr", {31'h0, mem_err}, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
            checkOutput("midInitReady", {31'h0, mem_ready}, 32'h0);
            checkOutput("midInitMmio", mmio_out, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("resweepReady", {31'h0, mem_ready}, 32'h1);
        checkOutput("resweepData40", mem_data_o, 32'h0);
        checkOutput("resweepErr", {31'h0, mem_err}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("resweepData4", mem_data_o, 32'h0);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] addr;
            int          pick;
            pick = int'($urandom_range(0, 31));
            addr = $urandom & 32'hFFFF_FFFC;
            if (pick == 0) addr = addr | 32'($urandom_range(1, 3));
            if (pick == 1 || pick == 2) addr = 32'hFFFF0000 | 32'($urandom_range(0, 4) * 4);
            applyStimulus(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), addr, $urandom);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
